// File: rtl/inv_key_expander_pkg.sv
// Shared AES definitions: key/word types, round constants, and the
// inverse key schedule state encoding.
package inv_key_expander_pkg;

  typedef logic [127:0] key_t;
  typedef logic [31:0]  word_t;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Round constant for round i (1..10). Any other index yields 00.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inv_key_expander_sbox.sv
// Combinational forward AES S-box: multiplicative inverse in GF(2^8)
// followed by the AES affine transform.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 naturally
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(a, a);
    acc = sq;
    for (int unsigned i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] w_inv;

  // Inverse then affine transform (sum of left rotations 0..4, plus 0x63)
  always_comb begin
    w_inv  = gf_inv(i_byte);
    o_byte = w_inv
           ^ {w_inv[6:0], w_inv[7]}
           ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]}
           ^ {w_inv[3:0], w_inv[7:4]}
           ^ 8'h63;
  end

endmodule

// File: rtl/inv_key_expander.sv
// AES-128 inverse key schedule: loads the round-10 key and streams round
// keys 10 down to 0 over a valid/ready handshake, one per accepted beat.
module inv_key_expander
  import inv_key_expander_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] last_key,
  input  logic         key_ready,
  output logic         busy,
  output logic         key_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         done
);

  state_t     r_state;
  state_t     w_state_nxt;
  key_t       r_key;
  key_t       w_key_nxt;
  logic [3:0] r_idx;
  logic [3:0] w_idx_nxt;
  logic       r_done;
  logic       w_done_nxt;

  word_t      w_k0, w_k1, w_k2, w_k3;
  word_t      w_p0, w_p1, w_p2, w_p3;
  word_t      w_rot;
  word_t      w_sub;
  key_t       w_prev;

  // Backward step: recover round i-1 words from round i words
  always_comb begin
    w_k0  = r_key[127:96];
    w_k1  = r_key[95:64];
    w_k2  = r_key[63:32];
    w_k3  = r_key[31:0];
    w_p3  = w_k3 ^ w_k2;
    w_p2  = w_k2 ^ w_k1;
    w_p1  = w_k1 ^ w_k0;
    w_rot = {w_p3[23:0], w_p3[31:24]};
    w_p0  = w_k0 ^ w_sub ^ {rcon(r_idx), 24'h0};
    w_prev = {w_p0, w_p1, w_p2, w_p3};
  end

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  // State, key, round counter and done pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state: load on start in IDLE, step backwards on each handshake
  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_key_nxt   = last_key;
          w_idx_nxt   = LAST_ROUND;
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (key_ready) begin
          if (r_idx == 4'd0) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_key_nxt = w_prev;
            w_idx_nxt = r_idx - 4'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy      = (r_state == ST_EMIT);
  assign key_valid = (r_state == ST_EMIT);
  assign round_key = r_key;
  assign round_idx = r_idx;
  assign done      = r_done;

endmodule

// File: tb/tb_inv_key_expander.sv
// Directed and randomized-key bench for the inverse key schedule; expected
// keys come from an independent table-driven forward expansion.
module tb_inv_key_expander;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] last_key;
  logic         key_ready;
  logic         busy;
  logic         key_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         done;

  int n_total;
  int n_bad;

  logic [127:0] g_rk [0:10];

  logic [7:0] sb [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic [7:0] rc [0:10] = '{8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

  localparam logic [127:0] A1_K0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  inv_key_expander u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .last_key  (last_key),
    .key_ready (key_ready),
    .busy      (busy),
    .key_valid (key_valid),
    .round_key (round_key),
    .round_idx (round_idx),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Forward AES-128 key expansion from the round-0 key into g_rk[0..10]
  task automatic fwd_expand(input logic [127:0] k0);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) g_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Runs one full sequence; called and returns at a negedge (the done cycle)
  task automatic do_seq(input logic [127:0] k0, input int mode, input bit hand,
                        input int inj_round, input logic [127:0] inj_key);
    int  exp_idx;
    int  cyc;
    bit  fin;
    bit  injected;
    bit  rdy;
    fwd_expand(k0);
    start     = 1'b1;
    last_key  = g_rk[10];
    key_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    exp_idx  = 10;
    cyc      = 0;
    fin      = 1'b0;
    injected = 1'b0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (exp_idx == inj_round && !injected) begin
        start    = 1'b1;
        last_key = inj_key;
        injected = 1'b1;
      end
      rdy = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      key_ready = rdy;
      check_eq("valid", 128'(key_valid), 128'(1));
      check_eq("busy", 128'(busy), 128'(1));
      check_eq("done_low", 128'(done), 128'(0));
      check_eq("idx", 128'(round_idx), 128'(exp_idx));
      check_eq("key", round_key, g_rk[exp_idx]);
      if (hand) begin
        if (cyc == 1)  check_eq("a1_idx10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        if (cyc == 2)  check_eq("a1_idx9",  round_key, 128'hac7766f319fadc2128d12941575c006e);
        if (cyc == 10) check_eq("a1_idx1",  round_key, 128'ha0fafe1788542cb123a339392a6c7605);
        if (cyc == 11) check_eq("a1_idx0",  round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      end
      if (rdy) begin
        if (exp_idx == 0) fin = 1'b1;
        else exp_idx--;
      end
    end
    start = 1'b0;
    if (!fin) check_eq("seq_timeout", 128'(0), 128'(1));
    @(negedge clk);
    if (hand) check_eq("a1_done_cycle", 128'(cyc + 1), 128'(12));
    check_eq("done_pulse", 128'(done), 128'(1));
    check_eq("busy_off", 128'(busy), 128'(0));
    check_eq("valid_off", 128'(key_valid), 128'(0));
  endtask

  task automatic idle_check();
    @(negedge clk);
    check_eq("done_clear", 128'(done), 128'(0));
    check_eq("idle_valid", 128'(key_valid), 128'(0));
    check_eq("idle_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    int wait_cnt;
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    key_ready = 1'b0;
    last_key  = '0;
    #12;
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_valid", 128'(key_valid), 128'(0));
    check_eq("rst_done", 128'(done), 128'(0));
    check_eq("rst_key", round_key, 128'(0));
    check_eq("rst_idx", 128'(round_idx), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 A.1 with key_ready high
    do_seq(A1_K0, 0, 1'b1, -1, '0);
    idle_check();

    // Same key under random backpressure
    do_seq(A1_K0, 1, 1'b0, -1, '0);
    idle_check();

    // start with a different key at round 5 must be ignored
    do_seq(A1_K0, 0, 1'b0, 5, 128'h00112233445566778899aabbccddeeff);
    idle_check();

    // Asynchronous reset at round 4, then a fresh sequence
    fwd_expand(A1_K0);
    start     = 1'b1;
    last_key  = g_rk[10];
    key_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_cnt = 0;
    do begin
      @(negedge clk);
      wait_cnt++;
    end while (round_idx != 4'd4 && wait_cnt < 30);
    check_eq("reach_round4", 128'(round_idx), 128'(4));
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 128'(busy), 128'(0));
    check_eq("arst_valid", 128'(key_valid), 128'(0));
    check_eq("arst_done", 128'(done), 128'(0));
    check_eq("arst_key", round_key, 128'(0));
    check_eq("arst_idx", 128'(round_idx), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_seq(128'h000102030405060708090a0b0c0d0e0f, 0, 1'b0, -1, '0);
    idle_check();

    // 100 random keys chained back-to-back (start in each done cycle)
    for (int n = 0; n < 100; n++) begin
      do_seq({$urandom, $urandom, $urandom, $urandom}, n % 2, 1'b0, -1, '0);
    end
    idle_check();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
